// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stopwatch_pkg                                             |
// | Purpose  : State encodings and default sizes for the stopwatch path  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SPLIT = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } sw_state_t;

  localparam int c_cnt_w_default      = 24;
  localparam int c_lap_depth_default  = 8;
  localparam int c_hold_ticks_default = 2000;

endpackage
`default_nettype wire

// File: rtl/stopwatch_lap_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stopwatch_lap_buf                                         |
// | Purpose  : Saturating lap register file with combinational read      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module stopwatch_lap_buf
  import stopwatch_pkg::*;
#(
  parameter int CNT_W     = c_cnt_w_default,
  parameter int LAP_DEPTH = c_lap_depth_default
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           push,
  input  logic [CNT_W-1:0]               push_data,
  input  logic [$clog2(LAP_DEPTH)-1:0]   rd_idx,
  output logic [CNT_W-1:0]               rd_data,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_full
);

  localparam int c_idx_w = $clog2(LAP_DEPTH);
  localparam int c_num_w = $clog2(LAP_DEPTH + 1);
  localparam logic [c_num_w-1:0] c_depth = c_num_w'(LAP_DEPTH);

  logic [CNT_W-1:0]   r_mem [LAP_DEPTH];
  logic [c_num_w-1:0] r_count;
  logic [c_num_w-1:0] w_rd_ext;

  assign lap_count = r_count;
  assign lap_full  = (r_count == c_depth);
  assign w_rd_ext  = {1'b0, rd_idx};
  // Entries at or beyond the fill level read as zero, not stale data.
  assign rd_data   = (w_rd_ext < r_count) ? r_mem[rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_count <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (push && !lap_full) begin
      r_mem[r_count[c_idx_w-1:0]] <= push_data;
      r_count                     <= r_count + c_num_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stopwatch_lap_ctrl                                        |
// | Purpose  : Stopwatch control FSM with countdown, split hold and laps |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_W      = c_cnt_w_default,
  parameter int LAP_DEPTH  = c_lap_depth_default,
  parameter int HOLD_TICKS = c_hold_ticks_default
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clk_en,
  input  logic                           start_pause_btn,
  input  logic                           lap_btn,
  input  logic                           reset_btn,
  input  logic                           mode_down,
  input  logic [CNT_W-1:0]               timer_value,
  input  logic                           timer_zero,
  input  logic [$clog2(LAP_DEPTH)-1:0]   lap_rd_idx,
  output logic                           counting,
  output logic                           count_down,
  output logic                           reset_timer,
  output logic                           load_preset,
  output logic                           frozen,
  output logic [CNT_W-1:0]               snap_value,
  output logic                           done,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
  output logic                           lap_full,
  output logic [CNT_W-1:0]               lap_rd_data
);

  localparam int c_hold_w = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_TICKS - 1);

  sw_state_t           r_state;
  logic                r_sp_prev;
  logic                r_lap_prev;
  logic [c_hold_w-1:0] r_hold;
  logic                r_count_down;
  logic                r_load_preset;
  logic                r_counting;
  logic                r_frozen;
  logic                r_done;
  logic [CNT_W-1:0]    r_snap;

  logic w_sp_edge;
  logic w_lap_edge;
  logic w_active;
  logic w_expire;
  logic w_push;
  logic w_clear;

  assign w_sp_edge  = r_sp_prev  & ~start_pause_btn;
  assign w_lap_edge = r_lap_prev & ~lap_btn;
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_SPLIT);
  assign w_expire   = r_count_down & timer_zero & w_active;
  // Mirrors the capture arms of the FSM below so file and snapshot stay in step.
  assign w_push     = clk_en & reset_btn & w_active & ~w_expire & ~w_sp_edge & w_lap_edge;
  assign w_clear    = clk_en & ~reset_btn;

  assign reset_timer = ~reset_btn;
  assign counting    = r_counting;
  assign count_down  = r_count_down;
  assign load_preset = r_load_preset;
  assign frozen      = r_frozen;
  assign done        = r_done;
  assign snap_value  = r_snap;

  always_ff @(posedge clk) begin
    r_load_preset <= 1'b0;
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sp_prev    <= 1'b1;
      r_lap_prev   <= 1'b1;
      r_hold       <= '0;
      r_count_down <= 1'b0;
      r_counting   <= 1'b0;
      r_frozen     <= 1'b0;
      r_done       <= 1'b0;
      r_snap       <= '0;
    end else if (clk_en) begin
      r_sp_prev  <= start_pause_btn;
      r_lap_prev <= lap_btn;
      if (!reset_btn) begin
        r_state      <= ST_IDLE;
        r_hold       <= '0;
        r_count_down <= 1'b0;
        r_counting   <= 1'b0;
        r_frozen     <= 1'b0;
        r_done       <= 1'b0;
        r_snap       <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_sp_edge) begin
              r_state       <= ST_RUN;
              r_counting    <= 1'b1;
              r_count_down  <= mode_down;
              r_load_preset <= mode_down;
            end
          end
          ST_RUN, ST_SPLIT: begin
            if (w_expire) begin
              r_state    <= ST_DONE;
              r_counting <= 1'b0;
              r_frozen   <= 1'b0;
              r_done     <= 1'b1;
            end else if (w_sp_edge) begin
              r_state    <= ST_PAUSE;
              r_counting <= 1'b0;
              r_frozen   <= 1'b0;
            end else if (w_lap_edge) begin
              r_state  <= ST_SPLIT;
              r_frozen <= 1'b1;
              r_snap   <= timer_value;
              r_hold   <= c_hold_load;
            end else if (r_state == ST_SPLIT) begin
              if (r_hold == '0) begin
                r_state  <= ST_RUN;
                r_frozen <= 1'b0;
              end else begin
                r_hold <= r_hold - c_hold_w'(1);
              end
            end
          end
          ST_PAUSE: begin
            if (w_sp_edge) begin
              r_state    <= ST_RUN;
              r_counting <= 1'b1;
            end
          end
          ST_DONE: begin
          end
          default: begin
            r_state    <= ST_IDLE;
            r_counting <= 1'b0;
            r_frozen   <= 1'b0;
            r_done     <= 1'b0;
          end
        endcase
      end
    end
  end

  stopwatch_lap_buf #(
    .CNT_W     (CNT_W),
    .LAP_DEPTH (LAP_DEPTH)
  ) u_lap_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .push      (w_push),
    .push_data (timer_value),
    .rd_idx    (lap_rd_idx),
    .rd_data   (lap_rd_data),
    .lap_count (lap_count),
    .lap_full  (lap_full)
  );

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_stopwatch_lap_ctrl                                     |
// | Purpose  : Directed and random checks of stopwatch_lap_ctrl          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_stopwatch_lap_ctrl;

  localparam int CNT_W      = 24;
  localparam int LAP_DEPTH  = 2;
  localparam int HOLD_TICKS = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_en = 1'b0;
  logic             start_pause_btn = 1'b1;
  logic             lap_btn = 1'b1;
  logic             reset_btn = 1'b1;
  logic             mode_down = 1'b0;
  logic [CNT_W-1:0] timer_value = '0;
  logic             timer_zero = 1'b0;
  logic [0:0]       lap_rd_idx = '0;
  logic             counting, count_down, reset_timer, load_preset, frozen, done, lap_full;
  logic [CNT_W-1:0] snap_value, lap_rd_data;
  logic [1:0]       lap_count;

  int total = 0;
  int bad   = 0;

  // Reference model: mode name, lap list and ticks of freeze remaining.
  string            m_mode = "idle";
  logic [CNT_W-1:0] m_laps[$];
  logic [CNT_W-1:0] m_snap = '0;
  int               m_left = 0;
  logic             m_down = 1'b0;
  logic             m_load = 1'b0;
  logic             m_sp_prev = 1'b1;
  logic             m_lap_prev = 1'b1;

  stopwatch_lap_ctrl #(
    .CNT_W      (CNT_W),
    .LAP_DEPTH  (LAP_DEPTH),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clk_en          (clk_en),
    .start_pause_btn (start_pause_btn),
    .lap_btn         (lap_btn),
    .reset_btn       (reset_btn),
    .mode_down       (mode_down),
    .timer_value     (timer_value),
    .timer_zero      (timer_zero),
    .lap_rd_idx      (lap_rd_idx),
    .counting        (counting),
    .count_down      (count_down),
    .reset_timer     (reset_timer),
    .load_preset     (load_preset),
    .frozen          (frozen),
    .snap_value      (snap_value),
    .done            (done),
    .lap_count       (lap_count),
    .lap_full        (lap_full),
    .lap_rd_data     (lap_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture();
    m_snap = timer_value;
    if (m_laps.size() < LAP_DEPTH) m_laps.push_back(timer_value);
    m_mode = "split";
    m_left = HOLD_TICKS;
  endtask

  task automatic model_tick();
    logic sp, lp;
    sp = m_sp_prev && !start_pause_btn;
    lp = m_lap_prev && !lap_btn;
    m_sp_prev  = start_pause_btn;
    m_lap_prev = lap_btn;
    m_load = 1'b0;
    if (!reset_btn) begin
      m_mode = "idle";
      m_laps.delete();
      m_snap = '0;
      m_down = 1'b0;
      m_left = 0;
    end else if (m_down && timer_zero && (m_mode == "run" || m_mode == "split")) begin
      m_mode = "done";
    end else if (m_mode == "idle") begin
      if (sp) begin
        m_mode = "run";
        m_down = mode_down;
        m_load = mode_down;
      end
    end else if (m_mode == "run") begin
      if (sp) m_mode = "pause";
      else if (lp) capture();
    end else if (m_mode == "split") begin
      if (sp) m_mode = "pause";
      else if (lp) capture();
      else begin
        m_left--;
        if (m_left == 0) m_mode = "run";
      end
    end else if (m_mode == "pause") begin
      if (sp) m_mode = "run";
    end
  endtask

  // One clk_en period of 10 clk; load_preset is checked on both cycles after the tick.
  task automatic tick();
    model_tick();
    clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    chk("load_preset_pulse", load_preset, m_load);
    @(posedge clk); #1;
    chk("load_preset_low", load_preset, 0);
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [CNT_W-1:0] e0, e1;
    e0 = (m_laps.size() > 0) ? m_laps[0] : '0;
    e1 = (m_laps.size() > 1) ? m_laps[1] : '0;
    chk({tag, ":counting"}, counting, (m_mode == "run" || m_mode == "split"));
    chk({tag, ":frozen"}, frozen, (m_mode == "split"));
    chk({tag, ":done"}, done, (m_mode == "done"));
    chk({tag, ":count_down"}, count_down, m_down);
    chk({tag, ":snap"}, snap_value, m_snap);
    chk({tag, ":lap_count"}, lap_count, m_laps.size());
    chk({tag, ":lap_full"}, lap_full, (m_laps.size() == LAP_DEPTH));
    chk({tag, ":reset_timer"}, reset_timer, !reset_btn);
    lap_rd_idx = 1'b0; #1;
    chk({tag, ":rd0"}, lap_rd_data, e0);
    lap_rd_idx = 1'b1; #1;
    chk({tag, ":rd1"}, lap_rd_data, e1);
  endtask

  task automatic press_sp(input string tag);
    start_pause_btn = 1'b0; tick(); check_all(tag);
    start_pause_btn = 1'b1; tick(); check_all(tag);
  endtask

  task automatic press_lap(input string tag, input logic [CNT_W-1:0] val);
    timer_value = val;
    lap_btn = 1'b0; tick(); check_all(tag);
    lap_btn = 1'b1; tick(); check_all(tag);
  endtask

  task automatic press_reset(input string tag);
    reset_btn = 1'b0; tick(); check_all(tag);
    reset_btn = 1'b1; tick(); check_all(tag);
  endtask

  initial begin
    // Reset overrides a simultaneous tick.
    rst_n  = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    clk_en = 1'b0;
    chk("rst_counting", counting, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_done", done, 0);
    chk("rst_count_down", count_down, 0);
    chk("rst_load_preset", load_preset, 0);
    chk("rst_snap", snap_value, 0);
    chk("rst_lap_count", lap_count, 0);
    chk("rst_lap_full", lap_full, 0);
    chk("rst_rd", lap_rd_data, 0);
    chk("rst_reset_timer", reset_timer, 0);
    repeat (5) @(posedge clk);
    #1;

    // Start / pause / resume.
    press_sp("start");
    chk("start_counting", counting, 1);
    press_sp("pause");
    chk("pause_counting", counting, 0);
    press_sp("resume");

    // Lap capture and hold duration.
    timer_value = 24'h000123;
    lap_btn = 1'b0; tick(); check_all("lap1");
    chk("lap1_frozen", frozen, 1);
    chk("lap1_snap", snap_value, 24'h123);
    chk("lap1_count", lap_count, 1);
    lap_btn = 1'b1;
    for (int i = 1; i <= HOLD_TICKS; i++) begin
      tick(); check_all("hold");
    end
    chk("hold_released", frozen, 0);
    chk("hold_counting", counting, 1);

    // Overflow: three laps into a two-entry file.
    press_reset("clr1");
    press_sp("start2");
    press_lap("ovf1", 24'h10);
    press_lap("ovf2", 24'h20);
    timer_value = 24'h30;
    lap_btn = 1'b0; tick(); check_all("ovf3");
    chk("ovf_count", lap_count, 2);
    chk("ovf_full", lap_full, 1);
    chk("ovf_snap", snap_value, 24'h30);
    lap_btn = 1'b1;
    for (int i = 1; i <= HOLD_TICKS; i++) begin
      tick(); check_all("ovf_hold");
    end
    chk("ovf_hold_end", frozen, 0);
    press_reset("clr2");
    lap_rd_idx = 1'b1; #1;
    chk("clr_rd1", lap_rd_data, 0);

    // Countdown expiry.
    mode_down = 1'b1;
    start_pause_btn = 1'b0; tick(); check_all("cd_start");
    chk("cd_count_down", count_down, 1);
    start_pause_btn = 1'b1; tick(); check_all("cd_rel");
    timer_zero = 1'b1;
    start_pause_btn = 1'b0; tick(); check_all("cd_expire");
    chk("cd_done", done, 1);
    chk("cd_counting", counting, 0);
    start_pause_btn = 1'b1; tick(); check_all("cd_rel2");
    press_sp("cd_stuck");
    chk("cd_still_done", done, 1);
    timer_zero = 1'b0;
    mode_down  = 1'b0;
    press_reset("clr3");

    // Reset button beats a simultaneous lap press in SPLIT.
    press_sp("start3");
    press_lap("rp_lap", 24'h55);
    lap_btn   = 1'b0;
    reset_btn = 1'b0;
    #1;
    chk("rp_reset_timer_now", reset_timer, 1);
    tick(); check_all("rp_reset");
    chk("rp_lap_count", lap_count, 0);
    chk("rp_snap", snap_value, 0);
    lap_btn   = 1'b1;
    reset_btn = 1'b1;
    tick(); check_all("rp_rel");

    // Simultaneous start + lap in RUN, then a pulse between ticks.
    press_sp("start4");
    start_pause_btn = 1'b0;
    lap_btn = 1'b0;
    tick(); check_all("simul");
    chk("simul_lap_count", lap_count, 0);
    start_pause_btn = 1'b1;
    lap_btn = 1'b1;
    tick(); check_all("simul_rel");
    start_pause_btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start_pause_btn = 1'b1;
    tick(); check_all("gated");
    chk("gated_paused", counting, 0);

    // Random phase against the model.
    for (int n = 0; n < 300; n++) begin
      start_pause_btn = ($urandom_range(0, 3) != 0);
      lap_btn         = ($urandom_range(0, 2) != 0);
      reset_btn       = ($urandom_range(0, 39) != 0);
      mode_down       = $urandom_range(0, 1);
      timer_zero      = ($urandom_range(0, 5) == 0);
      timer_value     = CNT_W'($urandom);
      tick();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
